// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential ReLU neuron.
// Define NEURON_ACC_SAT_EN to saturate the result instead of wrapping it.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  // Wide enough that any activation sum or result fits before reduction
  localparam int RW = 64;

  function automatic int acc_width(input int dw, input int n_in);
    return dw + $clog2(n_in);
  endfunction

  function automatic logic [RW-1:0] relu_reduce(input logic signed [RW-1:0] acc,
                                                input int ow);
    logic [RW-1:0] max_val;
    max_val = (RW'(1) << ow) - RW'(1);
    if (acc < 0) begin
      return '0;
    end
`ifdef NEURON_ACC_SAT_EN
    if (acc > $signed(max_val)) begin
      return max_val;
    end
    return acc & max_val;
`else
    return acc & max_val;
`endif
  endfunction

endpackage

// File: rtl/neuron_lane_sum.sv
// Combinational sum of LANES signed activations, sign-extended so the
// full-lane sum can never overflow.
module neuron_lane_sum #(
  parameter int DW    = 8,
  parameter int LANES = 2
) (
  input  logic [LANES*DW-1:0]                d,
  output logic signed [DW+$clog2(LANES):0]   sum
);

  localparam int SW = DW + $clog2(LANES) + 1;

  logic signed [SW-1:0] s;

  always_comb begin
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      s = s + SW'($signed(d[k*DW +: DW]));
    end
  end

  assign sum = s;

endmodule

// File: rtl/neuron_acc_seq.sv
// Sequential ReLU neuron: accumulates N_IN activations over N_IN/LANES beats.
// Define NEURON_ACC_SAT_EN to saturate Q at 2^OW-1; otherwise Q wraps.
module neuron_acc_seq
  import neuron_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int DW    = 8,
  parameter int LANES = 2,
  parameter int OW    = 8
) (
  input  logic                CK,
  input  logic                RST,
  input  logic [LANES*DW-1:0] D,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [OW-1:0]       Q,
  output logic                OUT_VALID,
  input  logic                OUT_READY
);

  localparam int AW = acc_width(DW, N_IN);
  localparam int NB = N_IN / LANES;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = DW + $clog2(LANES) + 1;
  // The true running sum always fits AW; XW only keeps the add width-clean
  localparam int XW = (SW > AW) ? SW : AW;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [SW-1:0] lane_sum;
  logic signed [XW-1:0] lane_x;
  logic signed [XW-1:0] acc_x;
  logic signed [XW-1:0] sum_x;
  logic                 take;
  logic                 last_beat;

  neuron_lane_sum #(
    .DW    (DW),
    .LANES (LANES)
  ) u_lane_sum (
    .d   (D),
    .sum (lane_sum)
  );

  assign take      = IN_VALID && IN_READY;
  // cnt is held at zero in IDLE, so this also covers the single-beat case
  assign last_beat = (cnt == CW'(NB - 1));

  assign lane_x   = XW'(lane_sum);
  assign acc_x    = XW'(acc);
  assign sum_x    = (state == IDLE) ? lane_x : (acc_x + lane_x);
  assign acc_next = AW'(sum_x);

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    IN_READY   = 1'b1;
    unique case (state)
      IDLE, ACC: begin
        if (take) begin
          state_next = last_beat ? OUT : ACC;
        end
      end
      OUT: begin
        IN_READY = 1'b0;
        if (OUT_READY) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Accumulate stage: acc/cnt update per beat, result captured on final beat
  always_ff @(posedge CK) begin
    if (RST) begin
      acc       <= '0;
      cnt       <= '0;
      Q         <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= (state_next == OUT);
      if (take) begin
        acc <= acc_next;
        cnt <= last_beat ? '0 : cnt + CW'(1);
        if (last_beat) begin
          Q <= OW'(relu_reduce(RW'(acc_next), OW));
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_acc_seq.sv
// Randomized self-checking bench for neuron_acc_seq (default and 8-lane builds).
module tb_neuron_acc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] d8;
  logic        in_valid8;
  logic        in_ready8;
  logic [9:0]  q8;
  logic        out_valid8;
  logic        out_ready8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_acc_seq #(.N_IN(8), .DW(8), .LANES(2), .OW(8)) u_dut (
    .CK(clk), .RST(rst), .D(d), .IN_VALID(in_valid), .IN_READY(in_ready),
    .Q(q), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  neuron_acc_seq #(.N_IN(8), .DW(8), .LANES(8), .OW(10)) u_dut8 (
    .CK(clk), .RST(rst), .D(d8), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .Q(q8), .OUT_VALID(out_valid8), .OUT_READY(out_ready8)
  );

  // Reference: ReLU of the plain integer sum, then saturate or wrap to ow bits
  function automatic int model_q(input int vals[8], input int ow);
    int s;
    int mx;
    s  = 0;
    mx = (1 << ow) - 1;
    foreach (vals[i]) s += vals[i];
    if (s < 0) return 0;
`ifdef NEURON_ACC_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s % (1 << ow);
`endif
  endfunction

  function automatic logic [63:0] pack8(input int vals[8]);
    logic [63:0] p;
    int          v;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      v = vals[k];
      p[k*8 +: 8] = v[7:0];
    end
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int a0, input int a1);
    int n;
    n = 0;
    d = {a1[7:0], a0[7:0]};
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_eval(input int vals[8], input bit gaps);
    for (int b = 0; b < 4; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      send_beat(vals[2*b], vals[2*b+1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; d8 = '0;
    step(); step();
    total++; if (q !== 8'd0) begin bad++; $display("FAIL reset_q: got %0d want 0", q); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    total++; if (q8 !== 10'd0) begin bad++; $display("FAIL reset_q8: got %0d want 0", q8); end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid8: got %0b want 0", out_valid8); end
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready8: got %0b want 1", in_ready8); end
    rst = 1'b0;
  endtask

  task automatic test_ones();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      send_beat(1, 1);
      if (b == 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ones_early_valid: got %0b want 0", out_valid); end
      end
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ones_valid: got %0b want 1", out_valid); end
    total++; if (q !== 8'd8) begin bad++; $display("FAIL ones_q: got %0d want 8", q); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ones_valid_drop: got %0b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ones_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_negative();
    int vals[8] = '{10, -20, 5, -15, 0, -3, 2, -9};
    out_ready = 1'b1;
    send_eval(vals, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL neg_valid: got %0b want 1", out_valid); end
    total++; if (q !== 8'd0) begin bad++; $display("FAIL neg_q: got %0d want 0", q); end
    step();
  endtask

  task automatic test_max();
    int vals[8] = '{127, 127, 127, 127, 127, 127, 127, 127};
    int exp;
    exp = model_q(vals, 8);
    out_ready = 1'b1;
    send_eval(vals, 1'b0);
    total++; if (q !== 8'(exp)) begin bad++; $display("FAIL max_q: got %0d want %0d", q, exp); end
    step();
  endtask

  task automatic test_hold();
    int vals[8];
    int exp;
    int ones[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) vals[i] = int'($urandom_range(0, 255)) - 128;
    exp = model_q(vals, 8);
    out_ready = 1'b0;
    send_eval(vals, 1'b1);
    for (int c = 0; c < 5; c++) begin
      total++; if (q !== 8'(exp) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d: q=%0d valid=%0b ready=%0b want q=%0d valid=1 ready=0",
                        c, q, out_valid, in_ready, exp);
      end
      in_valid = 1'b1;
      d = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    total++; if (q !== 8'(exp)) begin bad++; $display("FAIL hold_q_end: got %0d want %0d", q, exp); end
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %0b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %0b want 0", out_valid); end
    send_eval(ones, 1'b0);
    total++; if (q !== 8'd8) begin bad++; $display("FAIL hold_after_q: got %0d want 8", q); end
    step();
  endtask

  task automatic test_reset_mid();
    int ones[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    out_ready = 1'b1;
    send_beat(50, 50);
    send_beat(50, 50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 8'd0) begin
      bad++; $display("FAIL midreset_state: ready=%0b valid=%0b q=%0d want 1 0 0", in_ready, out_valid, q);
    end
    send_eval(ones, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midreset_valid: got %0b want 1", out_valid); end
    total++; if (q !== 8'd8) begin bad++; $display("FAIL midreset_q: got %0d want 8", q); end
    step();
  endtask

  task automatic test_random();
    int vals[8];
    int exp;
    int mode;
    for (int e = 0; e < 24; e++) begin
      mode = e % 3;
      for (int i = 0; i < 8; i++) begin
        case (mode)
          0:       vals[i] = int'($urandom_range(0, 255)) - 128;
          1:       vals[i] = int'($urandom_range(60, 127));
          default: vals[i] = -int'($urandom_range(0, 128));
        endcase
      end
      exp = model_q(vals, 8);
      out_ready = 1'b0;
      send_eval(vals, 1'b1);
      total++; if (out_valid !== 1'b1 || q !== 8'(exp)) begin
        bad++; $display("FAIL rand_eval%0d: valid=%0b q=%0d want valid=1 q=%0d", e, out_valid, q, exp);
      end
      repeat ($urandom_range(0, 3)) step();
      total++; if (q !== 8'(exp)) begin bad++; $display("FAIL rand_stable%0d: q=%0d want %0d", e, q, exp); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_drop%0d: valid=%0b want 0", e, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int v0[8] = '{100, 100, 100, 100, 100, 100, 100, -1};
    int v1[8];
    int v2[8];
    int exp[3];
    logic [63:0] pk[3];
    for (int i = 0; i < 8; i++) begin
      v1[i] = int'($urandom_range(0, 255)) - 128;
      v2[i] = int'($urandom_range(0, 127));
    end
    exp[0] = model_q(v0, 10);
    exp[1] = model_q(v1, 10);
    exp[2] = model_q(v2, 10);
    pk[0] = pack8(v0);
    pk[1] = pack8(v1);
    pk[2] = pack8(v2);
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    d8 = pk[0];
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k % 2 == 1) begin
        total++; if (out_valid8 !== 1'b1 || q8 !== 10'(exp[(k-1)/2])) begin
          bad++; $display("FAIL b2b_result%0d: valid=%0b q=%0d want valid=1 q=%0d",
                          (k-1)/2, out_valid8, q8, exp[(k-1)/2]);
        end
        if (k < 5) d8 = pk[(k+1)/2];
        else in_valid8 = 1'b0;
      end else begin
        total++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
          bad++; $display("FAIL b2b_gap%0d: valid=%0b ready=%0b want 0 1", k, out_valid8, in_ready8);
        end
      end
    end
    total++; if (exp[0] != 699) begin bad++; $display("FAIL b2b_ref699: got %0d want 699", exp[0]); end
    step();
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL b2b_idle: valid=%0b want 0", out_valid8); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_negative();
    test_max();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

endmodule
